// File: rtl/dma_sched_pkg.sv
// rtl/dma_sched_pkg.sv - shared types and width helpers for the DMA transfer scheduler
// Contents:
//   AddrWidth, LenWidth  descriptor field widths
//   desc_t               {src, dst, len} 1D transfer descriptor
//   stream_state_e       per-stream lifecycle IDLE -> ISSUE -> ACTIVE
//   idx_width()          index width that stays >= 1 for single-entry arrays
package dma_sched_pkg;

   localparam int AddrWidth = 64;
   localparam int LenWidth  = 32;

   typedef struct packed {
      logic [AddrWidth-1:0] src;
      logic [AddrWidth-1:0] dst;
      logic [LenWidth-1:0]  len;
   } desc_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      ACTIVE = 2'd2
   } stream_state_e;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dma_sched_stream_slot.sv
// rtl/dma_sched_stream_slot.sv - one backend stream: lifecycle FSM plus latched descriptor, owner and ID
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   grant_i        scheduler assigns a descriptor to this slot (only while idle)
//   desc_i         descriptor to latch on grant
//   owner_i        requester index to latch on grant
//   tf_id_i        transfer ID to latch on grant
//   ready_i        backend stream accepts the descriptor
//   done_i         backend completion pulse
//   idle_o         slot is IDLE (registered state)
//   valid_o        descriptor valid toward the backend (ISSUE state)
//   desc_o         latched descriptor
//   owner_o        latched owner index
//   tf_id_o        latched transfer ID
//   done_fire_o    completion accepted this cycle (done while ACTIVE)
module dma_sched_stream_slot
   import dma_sched_pkg::*;
#(
   parameter int OwnerWidth = 3,
   parameter int TfIdWidth  = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  grant_i,
   input  desc_t                 desc_i,
   input  logic [OwnerWidth-1:0] owner_i,
   input  logic [TfIdWidth-1:0]  tf_id_i,
   input  logic                  ready_i,
   input  logic                  done_i,
   output logic                  idle_o,
   output logic                  valid_o,
   output desc_t                 desc_o,
   output logic [OwnerWidth-1:0] owner_o,
   output logic [TfIdWidth-1:0]  tf_id_o,
   output logic                  done_fire_o
);

   stream_state_e state_q, state_d;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Done pulses outside ACTIVE are stale (e.g. from before a reset) and dropped.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (grant_i) state_d = ISSUE;
         ISSUE:   if (ready_i) state_d = ACTIVE;
         ACTIVE:  if (done_i)  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         desc_o  <= '0;
         owner_o <= '0;
         tf_id_o <= '0;
      end else if (grant_i) begin
         desc_o  <= desc_i;
         owner_o <= owner_i;
         tf_id_o <= tf_id_i;
      end
   end

   assign idle_o      = (state_q == IDLE);
   assign valid_o     = (state_q == ISSUE);
   assign done_fire_o = (state_q == ACTIVE) && done_i;

endmodule

// File: rtl/dma_tf_scheduler.sv
// rtl/dma_tf_scheduler.sv - shares 1D transfer descriptors from several requesters across DMA backend streams
// Ports:
//   clk_i, rst_i     clock, asynchronous active-high reset
//   req_valid_i      descriptor valid per requester
//   req_ready_o      descriptor accepted (one-hot or zero, combinational)
//   req_desc_i       descriptor per requester
//   req_tf_id_o      ID given to the descriptor accepted this cycle
//   stream_valid_o   descriptor valid toward each stream
//   stream_ready_i   stream accepts its descriptor
//   stream_desc_o    registered descriptor per stream
//   stream_done_i    completion pulse per stream
//   term_event_o     registered completion pulse per owning requester
//   completed_id_o   ID of the most recent completion
//   busy_o           any stream not IDLE
module dma_tf_scheduler
   import dma_sched_pkg::*;
#(
   parameter int NumReq         = 5,
   parameter int NumStreams     = 4,
   parameter int TfIdWidth      = 8,
   parameter int MaxOutstanding = 4
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic  [NumReq-1:0]           req_valid_i,
   output logic  [NumReq-1:0]           req_ready_o,
   input  desc_t [NumReq-1:0]           req_desc_i,
   output logic  [TfIdWidth-1:0]        req_tf_id_o,
   output logic  [NumStreams-1:0]       stream_valid_o,
   input  logic  [NumStreams-1:0]       stream_ready_i,
   output desc_t [NumStreams-1:0]       stream_desc_o,
   input  logic  [NumStreams-1:0]       stream_done_i,
   output logic  [NumReq-1:0]           term_event_o,
   output logic  [TfIdWidth-1:0]        completed_id_o,
   output logic                         busy_o
);

   localparam int ReqIdxW = idx_width(NumReq);
   localparam int StrIdxW = idx_width(NumStreams);
   localparam int CntW    = $clog2(MaxOutstanding + 1);
   localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);

   logic [TfIdWidth-1:0] tf_id_q;
   logic [ReqIdxW-1:0]   rr_ptr_q;
   logic [CntW-1:0]      out_cnt_q [NumReq];
   logic [CntW-1:0]      out_cnt_d [NumReq];

   logic [NumStreams-1:0] stream_idle;
   logic [NumStreams-1:0] stream_grant;
   logic [NumStreams-1:0] done_fire;
   logic [ReqIdxW-1:0]    slot_owner [NumStreams];
   logic [TfIdWidth-1:0]  slot_tf_id [NumStreams];

   logic                 any_idle;
   logic [StrIdxW-1:0]   free_idx;
   logic [NumReq-1:0]    eligible;
   logic                 gnt_found;
   logic                 accept;
   logic [ReqIdxW-1:0]   gnt_idx;
   desc_t                gnt_desc;
   logic                 gnt_zero;
   logic [NumReq-1:0]    term_d;
   logic [TfIdWidth-1:0] cid_d;

   // Lowest-index idle stream. Idleness comes from registered state, so a
   // stream finishing this cycle only becomes grantable next cycle.
   assign any_idle = |stream_idle;

   always_comb begin
      free_idx = '0;
      for (int s = NumStreams - 1; s >= 0; s--) begin
         if (stream_idle[s]) free_idx = StrIdxW'(s);
      end
   end

   // Zero-length descriptors never occupy a stream, so they do not need a free one.
   always_comb begin
      for (int r = 0; r < NumReq; r++) begin
         eligible[r] = req_valid_i[r] && (out_cnt_q[r] < MaxCnt) &&
                       ((req_desc_i[r].len == '0) || any_idle);
      end
   end

   // Round-robin: search starts at the index after the last grant.
   always_comb begin : rr_pick
      int j;
      gnt_found = 1'b0;
      gnt_idx   = '0;
      j         = 0;
      for (int k = 0; k < NumReq; k++) begin
         j = int'(rr_ptr_q) + k;
         if (j >= NumReq) j = j - NumReq;
         if (!gnt_found && eligible[j]) begin
            gnt_found = 1'b1;
            gnt_idx   = ReqIdxW'(j);
         end
      end
   end

   // Reset also masks the combinational handshake so every output reads 0 during reset.
   assign accept   = gnt_found && !rst_i;
   assign gnt_desc = req_desc_i[gnt_idx];
   assign gnt_zero = (gnt_desc.len == '0);

   always_comb begin
      req_ready_o = '0;
      if (accept) req_ready_o[gnt_idx] = 1'b1;
   end

   assign req_tf_id_o = tf_id_q;

   always_comb begin
      for (int s = 0; s < NumStreams; s++) begin
         stream_grant[s] = accept && !gnt_zero && (free_idx == StrIdxW'(s));
      end
   end

   for (genvar s = 0; s < NumStreams; s++) begin : g_slot
      dma_sched_stream_slot #(
         .OwnerWidth (ReqIdxW),
         .TfIdWidth  (TfIdWidth)
      ) u_slot (
         .clk_i       (clk_i),
         .rst_i       (rst_i),
         .grant_i     (stream_grant[s]),
         .desc_i      (gnt_desc),
         .owner_i     (gnt_idx),
         .tf_id_i     (tf_id_q),
         .ready_i     (stream_ready_i[s]),
         .done_i      (stream_done_i[s]),
         .idle_o      (stream_idle[s]),
         .valid_o     (stream_valid_o[s]),
         .desc_o      (stream_desc_o[s]),
         .owner_o     (slot_owner[s]),
         .tf_id_o     (slot_tf_id[s]),
         .done_fire_o (done_fire[s])
      );
   end

   // Completion bookkeeping. Streams are scanned upward so the highest-index
   // completion owns completed_id_o and overrides a same-cycle zero-length one.
   always_comb begin : completion
      logic [CntW-1:0] dec;
      logic            inc;
      term_d = '0;
      cid_d  = completed_id_o;
      dec    = '0;
      inc    = 1'b0;
      if (accept && gnt_zero) begin
         term_d[gnt_idx] = 1'b1;
         cid_d           = tf_id_q;
      end
      for (int s = 0; s < NumStreams; s++) begin
         if (done_fire[s]) begin
            term_d[slot_owner[s]] = 1'b1;
            cid_d                 = slot_tf_id[s];
         end
      end
      for (int r = 0; r < NumReq; r++) begin
         dec = '0;
         for (int s = 0; s < NumStreams; s++) begin
            if (done_fire[s] && (slot_owner[s] == ReqIdxW'(r))) dec = dec + CntW'(1);
         end
         inc          = accept && !gnt_zero && (gnt_idx == ReqIdxW'(r));
         out_cnt_d[r] = out_cnt_q[r] + CntW'(inc) - dec;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         tf_id_q        <= '0;
         rr_ptr_q       <= '0;
         term_event_o   <= '0;
         completed_id_o <= '0;
         for (int r = 0; r < NumReq; r++) out_cnt_q[r] <= '0;
      end else begin
         term_event_o   <= term_d;
         completed_id_o <= cid_d;
         for (int r = 0; r < NumReq; r++) out_cnt_q[r] <= out_cnt_d[r];
         if (accept) begin
            tf_id_q  <= tf_id_q + 1'b1;
            rr_ptr_q <= (gnt_idx == ReqIdxW'(NumReq - 1)) ? '0 : gnt_idx + 1'b1;
         end
      end
   end

   assign busy_o = ~&stream_idle;

endmodule

// File: tb/tb_dma_tf_scheduler.sv
// tb/tb_dma_tf_scheduler.sv - directed self-checking bench for dma_tf_scheduler
module tb_dma_tf_scheduler;
   import dma_sched_pkg::*;

   logic            clk = 1'b0;
   logic            rst;
   logic  [4:0]     req_valid;
   logic  [4:0]     req_ready;
   desc_t [4:0]     req_desc;
   logic  [7:0]     req_tf_id;
   logic  [3:0]     stream_valid;
   logic  [3:0]     stream_ready;
   desc_t [3:0]     stream_desc;
   logic  [3:0]     stream_done;
   logic  [4:0]     term_event;
   logic  [7:0]     completed_id;
   logic            busy;

   int total = 0;
   int bad   = 0;

   dma_tf_scheduler #(
      .NumReq         (5),
      .NumStreams     (4),
      .TfIdWidth      (8),
      .MaxOutstanding (4)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .req_valid_i    (req_valid),
      .req_ready_o    (req_ready),
      .req_desc_i     (req_desc),
      .req_tf_id_o    (req_tf_id),
      .stream_valid_o (stream_valid),
      .stream_ready_i (stream_ready),
      .stream_desc_o  (stream_desc),
      .stream_done_i  (stream_done),
      .term_event_o   (term_event),
      .completed_id_o (completed_id),
      .busy_o         (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic desc_t mk(input logic [63:0] s, input logic [63:0] d, input logic [31:0] l);
      desc_t r;
      r.src = s;
      r.dst = d;
      r.len = l;
      return r;
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      req_valid = '0;
      stream_done = '0;
      tick();
      rst = 1'b0;
      #1;
   endtask

   initial begin
      rst = 1'b1;
      req_valid = 5'b00001;
      req_desc = '0;
      req_desc[0] = mk(64'h8000_0000, 64'h1000_0100, 32'd64);
      stream_ready = '0;
      stream_done = '0;
      tick();
      tick();

      // reset state, with a request pending
      chk("rst_ready", req_ready, 5'b0);
      chk("rst_svalid", stream_valid, 4'b0);
      chk("rst_term", term_event, 5'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_cid", completed_id, 8'd0);
      chk("rst_id", req_tf_id, 8'd0);

      // single transfer
      rst = 1'b0;
      #1;
      chk("single_ready", req_ready, 5'b00001);
      chk("single_id", req_tf_id, 8'd0);
      tick();
      req_valid = '0;
      #1;
      chk("single_svalid", stream_valid, 4'b0001);
      chk("single_src", stream_desc[0].src, 64'h8000_0000);
      chk("single_dst", stream_desc[0].dst, 64'h1000_0100);
      chk("single_len", stream_desc[0].len, 64'd64);
      chk("single_busy", busy, 1'b1);
      stream_ready = 4'b0001;
      tick();
      stream_ready = '0;
      #1;
      chk("single_svalid_drop", stream_valid, 4'b0);
      tick();
      tick();
      stream_done = 4'b0001;
      tick();
      stream_done = '0;
      #1;
      chk("single_term", term_event, 5'b00001);
      chk("single_cid", completed_id, 8'd0);
      chk("single_idle", busy, 1'b0);
      tick();
      chk("single_term_end", term_event, 5'b0);

      // contention: five requesters, four streams
      do_reset();
      stream_ready = 4'b1111;
      for (int r = 0; r < 5; r++) req_desc[r] = mk(64'h100 * r, 64'h2000 + r, 32'd32 + r);
      req_valid = 5'b11111;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk($sformatf("cont_ready%0d", k), req_ready, 5'b1 << k);
         chk($sformatf("cont_id%0d", k), req_tf_id, k);
         tick();
         req_valid[k] = 1'b0;
      end
      #1;
      chk("cont_stall", req_ready, 5'b0);
      tick();
      chk("cont_stall2", req_ready, 5'b0);
      chk("cont_all_active", stream_valid, 4'b0);
      stream_done = 4'b0100;
      #1;
      chk("cont_done_same_cycle", req_ready, 5'b0);
      tick();
      stream_done = '0;
      #1;
      chk("cont_req4_ready", req_ready, 5'b10000);
      chk("cont_req4_id", req_tf_id, 8'd4);
      chk("cont_term2", term_event, 5'b00100);
      chk("cont_cid2", completed_id, 8'd2);
      tick();
      req_valid = '0;
      #1;
      chk("cont_s2_valid", stream_valid, 4'b0100);
      chk("cont_s2_dst", stream_desc[2].dst, 64'h2004);
      chk("cont_term_end", term_event, 5'b0);

      // outstanding limit on requester 2
      do_reset();
      stream_ready = 4'b1111;
      req_desc[2] = mk(64'h3000, 64'h4000, 32'd16);
      req_valid = 5'b00100;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk($sformatf("lim_ready%0d", k), req_ready, 5'b00100);
         chk($sformatf("lim_id%0d", k), req_tf_id, k);
         tick();
      end
      #1;
      chk("lim_fifth_held", req_ready, 5'b0);
      tick();
      chk("lim_fifth_held2", req_ready, 5'b0);
      stream_done = 4'b0010;
      #1;
      chk("lim_done_cycle", req_ready, 5'b0);
      tick();
      stream_done = '0;
      #1;
      chk("lim_fifth_ready", req_ready, 5'b00100);
      chk("lim_fifth_id", req_tf_id, 8'd4);
      chk("lim_term", term_event, 5'b00100);
      chk("lim_cid", completed_id, 8'd1);
      tick();
      req_valid = '0;
      tick();

      // zero-length with every stream active
      req_desc[1] = mk(64'h0, 64'h0, 32'd0);
      req_valid = 5'b00010;
      #1;
      chk("zl_busy_full", busy, 1'b1);
      chk("zl_ready", req_ready, 5'b00010);
      chk("zl_id", req_tf_id, 8'd5);
      tick();
      req_valid = '0;
      #1;
      chk("zl_term", term_event, 5'b00010);
      chk("zl_cid", completed_id, 8'd5);
      chk("zl_no_svalid", stream_valid, 4'b0);
      tick();
      chk("zl_term_end", term_event, 5'b0);

      // ID wrap and simultaneous completions
      do_reset();
      stream_ready = 4'b1111;
      req_desc[0] = mk(64'h0, 64'h0, 32'd0);
      req_valid = 5'b00001;
      repeat (255) tick();
      req_valid = '0;
      #1;
      chk("wrap_preload_id", req_tf_id, 8'd255);
      req_desc[1] = mk(64'h10, 64'h20, 32'd8);
      req_valid = 5'b00010;
      #1;
      chk("wrap_ready255", req_ready, 5'b00010);
      chk("wrap_id255", req_tf_id, 8'd255);
      tick();
      req_desc[0] = mk(64'h30, 64'h40, 32'd8);
      req_valid = 5'b00001;
      #1;
      chk("wrap_id0", req_tf_id, 8'd0);
      tick();
      req_desc[3] = mk(64'h50, 64'h60, 32'd8);
      req_valid = 5'b01000;
      tick();
      req_desc[2] = mk(64'h70, 64'h80, 32'd8);
      req_valid = 5'b00100;
      tick();
      req_valid = '0;
      tick();
      stream_done = 4'b1010;
      tick();
      stream_done = '0;
      #1;
      chk("sim_term", term_event, 5'b00101);
      chk("sim_cid", completed_id, 8'd2);
      chk("sim_busy", busy, 1'b1);
      tick();
      chk("sim_term_end", term_event, 5'b0);
      stream_done = 4'b0101;
      req_desc[4] = mk(64'h0, 64'h0, 32'd0);
      req_valid = 5'b10000;
      #1;
      chk("mix_zl_ready", req_ready, 5'b10000);
      chk("mix_zl_id", req_tf_id, 8'd3);
      tick();
      stream_done = '0;
      req_valid = '0;
      #1;
      chk("mix_term", term_event, 5'b11010);
      chk("mix_cid", completed_id, 8'd1);
      chk("mix_idle", busy, 1'b0);

      // reset in the middle of operation
      req_desc[0] = mk(64'h1, 64'h2, 32'd4);
      req_desc[1] = mk(64'h3, 64'h4, 32'd4);
      req_desc[2] = mk(64'h5, 64'h6, 32'd4);
      req_valid = 5'b00001;
      tick();
      req_valid = 5'b00010;
      tick();
      req_valid = 5'b00100;
      tick();
      req_valid = '0;
      tick();
      chk("mid_busy", busy, 1'b1);
      #2;
      rst = 1'b1;
      req_valid = 5'b01000;
      #1;
      chk("mid_ready", req_ready, 5'b0);
      chk("mid_svalid", stream_valid, 4'b0);
      chk("mid_busy_rst", busy, 1'b0);
      chk("mid_term", term_event, 5'b0);
      chk("mid_cid", completed_id, 8'd0);
      chk("mid_id", req_tf_id, 8'd0);
      tick();
      tick();
      rst = 1'b0;
      req_valid = '0;
      stream_done = 4'b0111;
      tick();
      stream_done = '0;
      #1;
      chk("post_term", term_event, 5'b0);
      chk("post_busy", busy, 1'b0);
      tick();
      chk("post_term2", term_event, 5'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
